axis_sync_fifo: RTL

Parametrised single-clock AXI4-Stream FIFO. It is the successor to the team's first-generation stream FIFO.
- Proper tvalid/tready handshakes on both sides, with first-word-fall-through output.
- Adds fill-level and threshold flags, synchronous flush, and optional store-and-forward packet mode.
- Sits between stream producers (DMA, packetiser) and consumers in the datapath.

---
 rtl/axis_fifo_pkg.sv | 22 ++
 rtl/axis_sync_fifo_if.sv | 12 +
 rtl/axis_fifo_ram.sv | 28 ++
 rtl/axis_sync_fifo.sv | 130 +++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers for the AXI4-Stream FIFO.
package axis_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Level counts up to DEPTH inclusive, hence one extra bit.
  function automatic int lvl_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo_if.sv
// AXI4-Stream handshake bundle used on both sides of the FIFO.
interface axis_sync_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register doubles as the FIFO output register, so only it is reset.
module axis_fifo_ram #(
  parameter int WIDTH   = 33,
  parameter int ENTRIES = 2047,
  parameter int AW      = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO with level flags and flush.
// Define AXIS_SYNC_FIFO_PKT_MODE_EN for store-and-forward packet mode.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  axis_sync_fifo_if.slave         s_axis,
  axis_sync_fifo_if.master        m_axis,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    almost_full,
  output logic                    almost_empty
);
  localparam int PW      = ptr_w(DEPTH);
  localparam int LW      = lvl_w(DEPTH);
  localparam int ENTRIES = DEPTH - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  typedef struct packed {
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
  } word_t;

  word_t          wr_word;
  word_t          rd_word;
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic           out_vld;
  logic           tready_q;
  logic           out_gate;
  logic           push;
  logic           pop;
  logic           load;
  logic           ram_nonempty;
  logic [LW-1:0]  level_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_word      = '{tlast: s_axis.tlast, tdata: s_axis.tdata};
  assign push         = s_axis.tvalid && tready_q;
  assign pop          = m_axis.tvalid && m_axis.tready;
  // RAM holds everything except the word sitting in the output register.
  assign ram_nonempty = level > LW'(out_vld);
  assign load         = ram_nonempty && (!out_vld || pop);
  assign level_nxt    = level + LW'(push) - LW'(pop);

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = out_vld && out_gate;
  assign m_axis.tdata  = rd_word.tdata;
  assign m_axis.tlast  = rd_word.tlast;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      out_vld      <= 1'b0;
      tready_q     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      out_vld      <= 1'b0;
      tready_q     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (load) rptr <= ptr_inc(rptr);
      level        <= level_nxt;
      out_vld      <= load || (out_vld && !pop);
      tready_q     <= level_nxt < DEPTH_L;
      almost_full  <= level_nxt >= AF_L;
      almost_empty <= level_nxt <= AE_L;
    end
  end

`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
  logic [LW-1:0] pkt_cnt;
  logic          cut_q;
  logic          full;

  assign full = level == DEPTH_L;
  // A full FIFO with no complete packet would never drain; let it cut through.
  assign out_gate = (pkt_cnt != '0) || cut_q || full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt <= '0;
      cut_q   <= 1'b0;
    end else if (flush) begin
      pkt_cnt <= '0;
      cut_q   <= 1'b0;
    end else begin
      pkt_cnt <= pkt_cnt + LW'(push && s_axis.tlast) - LW'(pop && rd_word.tlast);
      if (pop && rd_word.tlast)      cut_q <= 1'b0;
      else if (full && pkt_cnt == '0) cut_q <= 1'b1;
    end
  end
`else
  assign out_gate = 1'b1;
`endif

  axis_fifo_ram #(
    .WIDTH  ($bits(word_t)),
    .ENTRIES(ENTRIES),
    .AW     (PW)
  ) u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (push && !flush),
    .wr_addr(wptr),
    .wr_data(wr_word),
    .rd_en  (load && !flush),
    .rd_addr(rptr),
    .rd_data(rd_word)
  );
endmodule
